// File: rtl/data_mem_responder.sv
// Memory-stage data RAM responder: one load/store at a time, fixed wait states,
// byte-lane writes, RV32I load extension and a single-cycle response pulse.
module data_mem_responder #(
   parameter int WIDTH       = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_we_i,
   input  logic [WIDTH-1:0] req_addr_i,
   input  logic [WIDTH-1:0] req_wdata_i,
   input  logic [2:0]       req_funct3_i,
   output logic             rsp_valid_o,
   output logic [WIDTH-1:0] rsp_rdata_o,
   output logic             rsp_err_o,
   output logic             stall_o
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int NB = WIDTH / 8;
   localparam logic [CW-1:0]    WAIT_LOAD   = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [WIDTH-1:0] DEPTH_LIMIT = WIDTH'(DEPTH_WORDS);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             reqWe_q, reqWe_d;
   logic [AW+1:0]    reqAddr_q, reqAddr_d;
   logic [WIDTH-1:0] reqWdata_q, reqWdata_d;
   logic [2:0]       reqFunct3_q, reqFunct3_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             access;
   logic             inErr;
   logic             accWe;
   logic [AW+1:0]    accAddr;
   logic [WIDTH-1:0] accWdata;
   logic [2:0]       accFunct3;
   logic [1:0]       lane;
   logic [AW-1:0]    wordIdx;
   logic [WIDTH-1:0] rdWord;
   logic [7:0]       byteSel;
   logic [15:0]      halfSel;
   logic [WIDTH-1:0] loadData;
   logic [NB-1:0]    byteEn;
   logic [WIDTH-1:0] storeData;
   logic             memWe;

   logic [WIDTH-1:0] mem [DEPTH_WORDS];

   function automatic logic reqError(input logic we, input logic [WIDTH-1:0] addr,
                                     input logic [2:0] f3);
      logic bad;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = addr[0];
         F3_W:    bad = (addr[1:0] != 2'b00);
         F3_BU:   bad = we;
         F3_HU:   bad = we | addr[0];
         default: bad = 1'b1;
      endcase
      return bad | ((addr >> 2) >= DEPTH_LIMIT);
   endfunction

   assign inErr = reqError(req_we_i, req_addr_i, req_funct3_i);

   // With zero wait states the access happens on the accept edge, so it must see the live inputs.
   always_comb begin
      if (state_q == S_IDLE) begin
         accWe     = req_we_i;
         accAddr   = req_addr_i[AW+1:0];
         accWdata  = req_wdata_i;
         accFunct3 = req_funct3_i;
      end else begin
         accWe     = reqWe_q;
         accAddr   = reqAddr_q;
         accWdata  = reqWdata_q;
         accFunct3 = reqFunct3_q;
      end
   end

   assign lane    = accAddr[1:0];
   assign wordIdx = accAddr[AW+1:2];
   assign rdWord  = mem[wordIdx];
   assign byteSel = rdWord[{lane, 3'b000} +: 8];
   assign halfSel = rdWord[{lane[1], 4'b0000} +: 16];

   always_comb begin
      loadData  = rdWord;
      byteEn    = '1;
      storeData = accWdata;
      case (accFunct3)
         F3_B: begin
            loadData  = {{(WIDTH-8){byteSel[7]}}, byteSel};
            byteEn    = NB'(1) << lane;
            storeData = {NB{accWdata[7:0]}};
         end
         F3_H: begin
            loadData  = {{(WIDTH-16){halfSel[15]}}, halfSel};
            byteEn    = NB'(3) << lane;
            storeData = {(NB/2){accWdata[15:0]}};
         end
         F3_BU:   loadData = {{(WIDTH-8){1'b0}}, byteSel};
         F3_HU:   loadData = {{(WIDTH-16){1'b0}}, halfSel};
         default: loadData = rdWord;
      endcase
   end

   // Only the access edge ever writes, so a reset before it drops the store cleanly.
   assign memWe = access & accWe;

   always_ff @(posedge clk) begin
      if (memWe) begin
         for (int b = 0; b < NB; b++) begin
            if (byteEn[b]) begin
               mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      reqWe_d     = reqWe_q;
      reqAddr_d   = reqAddr_q;
      reqWdata_d  = reqWdata_q;
      reqFunct3_d = reqFunct3_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      access      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               reqWe_d     = req_we_i;
               reqAddr_d   = req_addr_i[AW+1:0];
               reqWdata_d  = req_wdata_i;
               reqFunct3_d = req_funct3_i;
               if (inErr) begin
                  state_d = S_RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else if (WAIT_CYCLES == 0) begin
                  access  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  cnt_d   = WAIT_LOAD;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (access) begin
         err_d   = 1'b0;
         rdata_d = accWe ? '0 : loadData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         reqWe_q     <= 1'b0;
         reqAddr_q   <= '0;
         reqWdata_q  <= '0;
         reqFunct3_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         reqWe_q     <= reqWe_d;
         reqAddr_q   <= reqAddr_d;
         reqWdata_q  <= reqWdata_d;
         reqFunct3_q <= reqFunct3_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign stall_o     = req_valid_i & ~rsp_valid_o;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a two-wait-state instance driven from a vector table
// plus hand sequences for reset abandonment and zero-wait back-to-back loads.
module tb_data_mem_responder;

   logic clk;
   logic rstN;

   logic        reqValid2, reqWe2, ready2, rspValid2, rspErr2, stall2;
   logic [31:0] reqAddr2, reqWdata2, rspRdata2;
   logic [2:0]  reqFunct32;

   logic        reqValid0, reqWe0, ready0, rspValid0, rspErr0, stall0;
   logic [31:0] reqAddr0, reqWdata0, rspRdata0;
   logic [2:0]  reqFunct30;

   logic        useZero;
   logic        selReady, selRspValid, selRspErr, selStall;
   logic [31:0] selRdata;

   int numCompared;
   int numMismatched;

   data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .rst_n(rstN),
      .req_valid_i(reqValid2), .req_ready_o(ready2), .req_we_i(reqWe2),
      .req_addr_i(reqAddr2), .req_wdata_i(reqWdata2), .req_funct3_i(reqFunct32),
      .rsp_valid_o(rspValid2), .rsp_rdata_o(rspRdata2), .rsp_err_o(rspErr2),
      .stall_o(stall2)
   );

   data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rstN),
      .req_valid_i(reqValid0), .req_ready_o(ready0), .req_we_i(reqWe0),
      .req_addr_i(reqAddr0), .req_wdata_i(reqWdata0), .req_funct3_i(reqFunct30),
      .rsp_valid_o(rspValid0), .rsp_rdata_o(rspRdata0), .rsp_err_o(rspErr0),
      .stall_o(stall0)
   );

   assign selReady    = useZero ? ready0    : ready2;
   assign selRspValid = useZero ? rspValid0 : rspValid2;
   assign selRspErr   = useZero ? rspErr0   : rspErr2;
   assign selRdata    = useZero ? rspRdata0 : rspRdata2;
   assign selStall    = useZero ? stall0    : stall2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] f3, input logic [31:0] expRdata,
                                  input logic expErr, input int expLat, input string name);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
      v.expRdata = expRdata; v.expErr = expErr; v.expLat = expLat; v.name = name;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      numCompared++;
      if (act !== exp) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic driveReq(input logic valid, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3);
      if (useZero) begin
         reqValid0 = valid; reqWe0 = we; reqAddr0 = addr; reqWdata0 = wdata; reqFunct30 = f3;
      end else begin
         reqValid2 = valid; reqWe2 = we; reqAddr2 = addr; reqWdata2 = wdata; reqFunct32 = f3;
      end
   endtask

   // Latency counts edges from the accept edge (inclusive) to the first sample showing rsp_valid.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                                output int lat, output logic stallOk);
      logic done;
      rdata = '0; err = 1'b0; lat = 0; stallOk = 1'b1; done = 1'b0;
      @(negedge clk);
      driveReq(1'b1, we, addr, wdata, f3);
      #1;
      if (selStall !== 1'b1 || selReady !== 1'b1) stallOk = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (!done) begin
            @(posedge clk);
            #1;
            if (selRspValid) begin
               done  = 1'b1;
               lat   = i;
               rdata = selRdata;
               err   = selRspErr;
               if (selStall !== 1'b0) stallOk = 1'b0;
            end else if (selStall !== 1'b1) begin
               stallOk = 1'b0;
            end
         end
      end
      driveReq(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      @(posedge clk);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic        stallOk;
      logic [31:0] vals [4];
      int          k;

      numCompared = 0;
      numMismatched = 0;
      useZero = 1'b0;
      rstN = 1'b0;
      reqValid2 = 0; reqWe2 = 0; reqAddr2 = 0; reqWdata2 = 0; reqFunct32 = 0;
      reqValid0 = 0; reqWe0 = 0; reqAddr0 = 0; reqWdata0 = 0; reqFunct30 = 0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("reset ready", {31'b0, ready2}, 32'd1);
      checkOutput("reset rsp_valid", {31'b0, rspValid2}, 32'd0);
      checkOutput("reset rdata", rspRdata2, 32'h0);
      checkOutput("reset err", {31'b0, rspErr2}, 32'd0);
      checkOutput("reset stall", {31'b0, stall2}, 32'd0);
      rstN = 1'b1;
      @(negedge clk);

      addVec(1, 32'h20,  32'hDEADBEEF, 3'b010, 32'h0,        0, 3, "SW 0x20");
      addVec(0, 32'h20,  32'h0,        3'b010, 32'hDEADBEEF, 0, 3, "LW 0x20");
      addVec(1, 32'h40,  32'h11223344, 3'b010, 32'h0,        0, 3, "SW 0x40");
      addVec(1, 32'h41,  32'h12345680, 3'b000, 32'h0,        0, 3, "SB 0x41");
      addVec(0, 32'h41,  32'h0,        3'b000, 32'hFFFFFF80, 0, 3, "LB 0x41");
      addVec(0, 32'h41,  32'h0,        3'b100, 32'h00000080, 0, 3, "LBU 0x41");
      addVec(0, 32'h40,  32'h0,        3'b010, 32'h11228044, 0, 3, "LW 0x40 merged");
      addVec(0, 32'h43,  32'h0,        3'b000, 32'h00000011, 0, 3, "LB 0x43");
      addVec(0, 32'h43,  32'h0,        3'b001, 32'h0,        1, 1, "LH 0x43 misaligned");
      addVec(1, 32'h22,  32'h55555555, 3'b010, 32'h0,        1, 1, "SW 0x22 misaligned");
      addVec(0, 32'h20,  32'h0,        3'b010, 32'hDEADBEEF, 0, 3, "LW 0x20 unchanged");
      addVec(0, 32'h1000, 32'h0,       3'b010, 32'h0,        1, 1, "LW out of range");
      addVec(0, 32'h20,  32'h0,        3'b011, 32'h0,        1, 1, "funct3 011");
      addVec(1, 32'h20,  32'h00000077, 3'b100, 32'h0,        1, 1, "SB funct3 100");
      addVec(1, 32'h20,  32'h00007777, 3'b101, 32'h0,        1, 1, "SH funct3 101");
      addVec(0, 32'h20,  32'h0,        3'b110, 32'h0,        1, 1, "funct3 110");
      addVec(0, 32'h20,  32'h0,        3'b111, 32'h0,        1, 1, "funct3 111");
      addVec(0, 32'h20,  32'h0,        3'b010, 32'hDEADBEEF, 0, 3, "LW 0x20 after errs");
      addVec(1, 32'h22,  32'hABCD1234, 3'b001, 32'h0,        0, 3, "SH 0x22");
      addVec(0, 32'h22,  32'h0,        3'b001, 32'h00001234, 0, 3, "LH 0x22");
      addVec(0, 32'h20,  32'h0,        3'b101, 32'h0000BEEF, 0, 3, "LHU 0x20");
      addVec(0, 32'h20,  32'h0,        3'b001, 32'hFFFFBEEF, 0, 3, "LH 0x20");
      addVec(0, 32'h20,  32'h0,        3'b010, 32'h1234BEEF, 0, 3, "LW 0x20 half merged");
      addVec(0, 32'h41,  32'h0,        3'b101, 32'h0,        1, 1, "LHU 0x41 misaligned");
      addVec(1, 32'hFFC, 32'hCAFEF00D, 3'b010, 32'h0,        0, 3, "SW last word");
      addVec(0, 32'hFFC, 32'h0,        3'b010, 32'hCAFEF00D, 0, 3, "LW last word");

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rdata, err, lat, stallOk);
         checkOutput({vecs[i].name, " rdata"}, rdata, vecs[i].expRdata);
         checkOutput({vecs[i].name, " err"}, {31'b0, err}, {31'b0, vecs[i].expErr});
         checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].expLat));
         checkOutput({vecs[i].name, " stall"}, {31'b0, stallOk}, 32'd1);
      end

      // Reset in the middle of a store's wait states drops it.
      @(negedge clk);
      driveReq(1'b1, 1'b1, 32'h10, 32'h0BADF00D, 3'b010);
      @(posedge clk);
      #1;
      checkOutput("midwait ready", {31'b0, ready2}, 32'd0);
      checkOutput("midwait rdata hold", rspRdata2, 32'hCAFEF00D);
      rstN = 1'b0;
      #1;
      checkOutput("midreset ready", {31'b0, ready2}, 32'd1);
      checkOutput("midreset rsp_valid", {31'b0, rspValid2}, 32'd0);
      checkOutput("midreset rdata", rspRdata2, 32'h0);
      checkOutput("midreset err", {31'b0, rspErr2}, 32'd0);
      @(negedge clk);
      driveReq(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, rdata, err, lat, stallOk);
      checkOutput("dropped store absent", {31'b0, rdata == 32'h0BADF00D}, 32'd0);
      checkOutput("post-reset LW err", {31'b0, err}, 32'd0);
      checkOutput("post-reset LW latency", 32'(lat), 32'd3);

      // Zero wait states: fill a few words, then hold valid high across back-to-back loads.
      useZero = 1'b1;
      vals[0] = 32'hA0000001; vals[1] = 32'hB0000002; vals[2] = 32'hC0000003; vals[3] = 32'hD0000004;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'(i * 4), vals[i], 3'b010, rdata, err, lat, stallOk);
         checkOutput("WC0 SW latency", 32'(lat), 32'd1);
         checkOutput("WC0 SW err", {31'b0, err}, 32'd0);
      end
      applyStimulus(1'b0, 32'h2, 32'h0, 3'b010, rdata, err, lat, stallOk);
      checkOutput("WC0 misaligned err", {31'b0, err}, 32'd1);
      checkOutput("WC0 misaligned latency", 32'(lat), 32'd1);

      k = 0;
      @(negedge clk);
      driveReq(1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
      for (int e = 0; e < 8; e++) begin
         @(posedge clk);
         #1;
         checkOutput("b2b rsp_valid", {31'b0, rspValid0}, {31'b0, (e % 2) == 0});
         checkOutput("b2b ready", {31'b0, ready0}, {31'b0, (e % 2) == 1});
         checkOutput("b2b stall", {31'b0, stall0}, {31'b0, reqValid0 & ((e % 2) == 1)});
         if (rspValid0) begin
            if (k < 4) checkOutput("b2b rdata", rspRdata0, vals[k]);
            k++;
            if (k < 4) driveReq(1'b1, 1'b0, 32'(k * 4), 32'h0, 3'b010);
            else driveReq(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
         end
      end
      checkOutput("b2b response count", 32'(k), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
